// File: rtl/prop_delay_meter.sv
// prop_delay_meter: measures, in clock samples, the latency from a stimulus
// change to the resulting change on the delay network output. Output pulses
// narrower than MIN_PULSE samples are flagged as glitches, and no response
// within TIMEOUT samples is reported as a timeout. Each result is a one-cycle
// strobe.
module prop_delay_meter #(
  parameter int WIDTH     = 4,
  parameter int CW        = 8,
  parameter int TIMEOUT   = 200,
  parameter int MIN_PULSE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] stim,
  input  logic             dut_out,
  output logic             busy,
  output logic             meas_valid,
  output logic [CW-1:0]    meas_cycles,
  output logic             meas_timeout,
  output logic             meas_glitch,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] PULSE_C   = CW'(MIN_PULSE);
  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};

  // Sampling pipeline: current and previous samples of both inputs.
  logic [WIDTH-1:0] stim_s;
  logic [WIDTH-1:0] stim_p;
  logic             out_s;
  logic             out_p;
  logic [1:0]       prime_sr_r;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    pw_r;
  logic [CW-1:0]    lat_r;
  logic             base_r;

  logic             event_s;
  logic             out_moved_s;
  state_t           arm_state_s;
  logic [CW-1:0]    arm_lat_s;

  // Register the inputs and their previous samples; priming tracks two post-reset samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stim_s     <= {WIDTH{1'b0}};
      stim_p     <= {WIDTH{1'b0}};
      out_s      <= 1'b0;
      out_p      <= 1'b0;
      prime_sr_r <= 2'b00;
    end else begin
      stim_s     <= stim;
      stim_p     <= stim_s;
      out_s      <= dut_out;
      out_p      <= out_s;
      prime_sr_r <= {prime_sr_r[0], 1'b1};
    end
  end

  // Detect stimulus events and decide where a fresh measurement starts.
  always_comb begin
    event_s     = 1'b0;
    out_moved_s = 1'b0;
    arm_state_s = MEAS;
    arm_lat_s   = ZERO_C;
    event_s     = prime_sr_r[1] && (stim_s != stim_p);
    out_moved_s = (out_s != out_p);
    if (out_moved_s) begin
      // Output changed on the very sample the stimulus did: zero latency.
      arm_state_s = HOLD;
    end else begin
      arm_state_s = MEAS;
    end
  end

  // Measurement state machine with registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= ZERO_C;
      pw_r         <= ZERO_C;
      lat_r        <= ZERO_C;
      base_r       <= 1'b0;
      busy         <= 1'b0;
      meas_valid   <= 1'b0;
      meas_cycles  <= ZERO_C;
      meas_timeout <= 1'b0;
      meas_glitch  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      meas_valid   <= 1'b0;
      meas_timeout <= 1'b0;
      meas_glitch  <= 1'b0;
      overrun      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (event_s) begin
            // Base is the output level before the stimulus change in both cases.
            state_r <= arm_state_s;
            base_r  <= out_p;
            cnt_r   <= ONE_C;
            pw_r    <= ONE_C;
            lat_r   <= arm_lat_s;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        MEAS: begin
          if (event_s) begin
            overrun <= 1'b1;
            state_r <= arm_state_s;
            base_r  <= out_p;
            cnt_r   <= ONE_C;
            pw_r    <= ONE_C;
            lat_r   <= arm_lat_s;
            busy    <= 1'b1;
          end else if (out_s != base_r) begin
            lat_r   <= cnt_r;
            pw_r    <= ONE_C;
            state_r <= HOLD;
          end else if (cnt_r == TIMEOUT_C) begin
            meas_valid   <= 1'b1;
            meas_timeout <= 1'b1;
            meas_cycles  <= TIMEOUT_C;
            state_r      <= IDLE;
            busy         <= 1'b0;
          end else begin
            cnt_r <= cnt_r + ONE_C;
          end
        end
        HOLD: begin
          if (event_s) begin
            // Report the pending result and start the next one on the same edge.
            meas_valid  <= 1'b1;
            meas_cycles <= lat_r;
            overrun     <= 1'b1;
            state_r     <= arm_state_s;
            base_r      <= out_p;
            cnt_r       <= ONE_C;
            pw_r        <= ONE_C;
            lat_r       <= arm_lat_s;
            busy        <= 1'b1;
          end else if (out_s == base_r) begin
            meas_valid  <= 1'b1;
            meas_glitch <= 1'b1;
            meas_cycles <= lat_r;
            state_r     <= IDLE;
            busy        <= 1'b0;
          end else if ((pw_r + ONE_C) == PULSE_C) begin
            meas_valid  <= 1'b1;
            meas_cycles <= lat_r;
            state_r     <= IDLE;
            busy        <= 1'b0;
          end else begin
            pw_r <= pw_r + ONE_C;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prop_delay_meter.sv
// Testbench for prop_delay_meter: directed test-plan scenarios plus random
// transactions, checked against a reference model that works on the recorded
// per-sample input history.
module tb_prop_delay_meter;
  localparam int WIDTH     = 4;
  localparam int CW        = 8;
  localparam int TIMEOUT   = 200;
  localparam int MIN_PULSE = 2;
  localparam int HMAX      = 8192;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] stim;
  logic             dut_out;
  logic             busy;
  logic             meas_valid;
  logic [CW-1:0]    meas_cycles;
  logic             meas_timeout;
  logic             meas_glitch;
  logic             overrun;

  prop_delay_meter #(
    .WIDTH(WIDTH), .CW(CW), .TIMEOUT(TIMEOUT), .MIN_PULSE(MIN_PULSE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stim(stim), .dut_out(dut_out),
    .busy(busy), .meas_valid(meas_valid), .meas_cycles(meas_cycles),
    .meas_timeout(meas_timeout), .meas_glitch(meas_glitch), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    int cyc;
    int to;
    int gl;
  } strobe_t;

  strobe_t obs_q[$];
  strobe_t exp_q[$];
  int      obs_ov[$];
  int      exp_ov[$];
  int      stim_h[HMAX];
  int      out_h[HMAX];
  int      e;
  int      n_checks = 0;
  int      n_errors = 0;
  logic [WIDTH-1:0] cur_st;
  logic             cur_o;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One sample: drive inputs, record them for the model, log DUT results.
  task automatic step(input logic [WIDTH-1:0] st, input logic o);
    strobe_t s;
    stim    = st;
    dut_out = o;
    @(posedge clk);
    e++;
    if (e >= HMAX) begin
      $display("FAIL history_overflow: got %0d, expected below %0d", e, HMAX);
      $fatal(1);
    end
    stim_h[e] = int'(st);
    out_h[e]  = int'(o);
    @(negedge clk);
    if (meas_valid) begin
      s.edge_no = e;
      s.cyc     = int'(meas_cycles);
      s.to      = int'(meas_timeout);
      s.gl      = int'(meas_glitch);
      obs_q.push_back(s);
    end
    if (overrun) obs_ov.push_back(e);
    check_val("flag_rule",
              int'((meas_timeout && meas_glitch) ||
                   ((meas_timeout || meas_glitch) && !meas_valid)), 0);
    cur_st = st;
    cur_o  = o;
  endtask

  // Reference model: derive every expected strobe/overrun from samples 1..n.
  // A change first sampled at k is acted on at edge k+1; base is the output
  // before the change; latency is the first later sample that differs from base.
  task automatic build_expected(input int n);
    int evs[$];
    int k, base, j, meas_end, end_e, d2;
    strobe_t s;
    exp_q.delete();
    exp_ov.delete();
    for (int i = 2; i <= n; i++)
      if (stim_h[i] != stim_h[i-1]) evs.push_back(i);
    for (int i = 0; i < evs.size(); i++) begin
      k    = evs[i];
      base = out_h[k-1];
      j    = -1;
      for (int t = k; t <= k + TIMEOUT && t <= n; t++)
        if (out_h[t] != base) begin
          j = t;
          break;
        end
      if (j < 0) begin
        meas_end  = k + 1 + TIMEOUT;
        end_e     = meas_end;
        s.edge_no = end_e;
        s.cyc     = TIMEOUT;
        s.to      = 1;
        s.gl      = 0;
      end else begin
        meas_end = j + 1;
        end_e    = j + MIN_PULSE;
        s.cyc    = j - k;
        s.to     = 0;
        s.gl     = 0;
        for (int p = 1; p < MIN_PULSE; p++)
          if (out_h[j+p] == base) begin
            s.gl  = 1;
            end_e = j + 1 + p;
            break;
          end
        s.edge_no = end_e;
      end
      if (i + 1 < evs.size() && evs[i+1] + 1 <= end_e) begin
        d2 = evs[i+1] + 1;
        exp_ov.push_back(d2);
        if (d2 > meas_end) begin
          // Interrupted while holding: result reported with no glitch.
          s.edge_no = d2;
          s.gl      = 0;
          exp_q.push_back(s);
        end
      end else if (end_e <= n) begin
        exp_q.push_back(s);
      end
    end
  endtask

  task automatic compare_all();
    int m;
    build_expected(e);
    check_val("strobe_count", obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check_val($sformatf("strobe%0d_edge", i), obs_q[i].edge_no, exp_q[i].edge_no);
      check_val($sformatf("strobe%0d_cycles", i), obs_q[i].cyc, exp_q[i].cyc);
      check_val($sformatf("strobe%0d_timeout", i), obs_q[i].to, exp_q[i].to);
      check_val($sformatf("strobe%0d_glitch", i), obs_q[i].gl, exp_q[i].gl);
    end
    check_val("overrun_count", obs_ov.size(), exp_ov.size());
    m = (obs_ov.size() < exp_ov.size()) ? obs_ov.size() : exp_ov.size();
    for (int i = 0; i < m; i++)
      check_val($sformatf("overrun%0d_edge", i), obs_ov[i], exp_ov[i]);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_busy"}, int'(busy), 0);
    check_val({pfx, "_valid"}, int'(meas_valid), 0);
    check_val({pfx, "_cycles"}, int'(meas_cycles), 0);
    check_val({pfx, "_timeout"}, int'(meas_timeout), 0);
    check_val({pfx, "_glitch"}, int'(meas_glitch), 0);
    check_val({pfx, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int mode, lat, gap;
    logic [WIDTH-1:0] st, st2;

    // Reset and priming
    rst_n   = 1'b0;
    stim    = 4'b1111;
    dut_out = 1'b1;
    cur_st  = 4'b1111;
    cur_o   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    e     = 0;
    obs_q.delete();
    obs_ov.delete();
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 1'b1);
      check_val("prime_busy", int'(busy), 0);
      check_val("prime_valid", int'(meas_valid), 0);
    end

    // Normal latency 3
    repeat (3) step(4'b1110, 1'b1);
    repeat (6) step(4'b1110, 1'b0);
    check_val("normal_cycles", int'(meas_cycles), 3);

    // Zero latency
    repeat (6) step(4'b1100, 1'b1);
    check_val("zero_cycles", int'(meas_cycles), 0);

    // Timeout
    repeat (TIMEOUT + 10) step(4'b1011, 1'b1);
    check_val("timeout_cycles", int'(meas_cycles), TIMEOUT);

    // Glitch at latency 5
    repeat (5) step(4'b0011, 1'b1);
    step(4'b0011, 1'b0);
    repeat (6) step(4'b0011, 1'b1);
    check_val("glitch_cycles", int'(meas_cycles), 5);

    // Overrun: second change during MEAS, latency counted from it
    repeat (2) step(4'b0001, 1'b1);
    repeat (4) step(4'b0000, 1'b1);
    repeat (6) step(4'b0000, 1'b0);
    check_val("overrun_cycles", int'(meas_cycles), 4);

    // Random transactions
    for (int t = 0; t < 30; t++) begin
      mode = int'($urandom_range(0, 9));
      lat  = int'($urandom_range(0, 12));
      gap  = int'($urandom_range(0, 4));
      st   = cur_st ^ 4'($urandom_range(1, 15));
      if (mode <= 4) begin
        repeat (lat) step(st, cur_o);
        step(st, !cur_o);
      end else if (mode <= 6) begin
        repeat (lat) step(st, cur_o);
        step(st, !cur_o);
        step(st, !cur_o);
      end else if (mode == 7) begin
        repeat (1 + lat % 4) step(st, cur_o);
        st2 = cur_st ^ 4'($urandom_range(1, 15));
        repeat (lat) step(st2, cur_o);
        step(st2, !cur_o);
      end else if (mode == 8 && (t % 3) == 0) begin
        repeat (TIMEOUT + 5) step(st, cur_o);
      end else begin
        step(st, !cur_o);
      end
      repeat (gap) step(cur_st, cur_o);
    end
    repeat (TIMEOUT + 50) step(cur_st, cur_o);
    compare_all();

    // Known result, then reset in the middle of a measurement
    st = cur_st ^ 4'b0110;
    repeat (4) step(st, cur_o);
    repeat (4) step(st, !cur_o);
    check_val("pre_reset_cycles", int'(meas_cycles), 4);
    st = cur_st ^ 4'b0101;
    repeat (4) step(st, cur_o);
    check_val("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    dut_out = !cur_o;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
